// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//   Elastic pipeline-stage register for the MIPS core's inter-stage boundaries
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data bundle and a control
//   bundle under a valid/ready handshake. A two-entry (main + skid) buffer
//   means in_ready depends only on registered state, plus flush and reset.
//   All state updates happen on the falling edge of clk.
//
// Parameters
//   DW          data bundle width
//   CW          control bundle width
//   CLEAR_DATA  1: data registers are zeroed on flush and when an entry drains
//               0: data registers keep their last value (control is still zeroed)
//
// Ports
//   clk        stage clock (falling-edge active)
//   reset      asynchronous, active-low reset
//   flush      synchronous bubble insert; drops every held entry
//   in_valid   upstream entry valid
//   in_ready   stage can accept this cycle
//   in_data    upstream data bundle
//   in_ctrl    upstream control bundle
//   out_valid  main entry valid
//   out_ready  downstream accepts this cycle
//   out_data   main entry data
//   out_ctrl   main entry control, forced to 0 whenever out_valid is 0
//
// Optional build macro: PIPE_STAGE_PERF_EN
//   When defined, two saturating 16-bit counters are added as outputs:
//   stall_cnt   cycles with in_valid=1 and in_ready=0
//   bubble_cnt  cycles with out_valid=0 while out of reset
//   Only reset clears them; flush leaves them alone.
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int DW         = 32,
    parameter int CW         = 12,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] in_ctrl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   bubble_cnt
`endif
);

    // The occupancy state is just the two valid bits. 2'b01 (skid valid with
    // main empty) cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } stateT;

    logic          mainValid, mainValidNxt;
    logic [DW-1:0] mainData,  mainDataNxt;
    logic [CW-1:0] mainCtrl,  mainCtrlNxt;
    logic          skidValid, skidValidNxt;
    logic [DW-1:0] skidData,  skidDataNxt;
    logic [CW-1:0] skidCtrl,  skidCtrlNxt;

    stateT state;
    logic  accept;
    logic  pop;

    assign state = stateT'({mainValid, skidValid});

    // in_ready only looks at registered skid occupancy, so upstream never
    // sees a path through to out_ready.
    assign in_ready = reset & ~skidValid & ~flush;
    assign accept   = in_valid & in_ready;
    assign pop      = mainValid & out_ready;

    assign out_valid = mainValid;
    assign out_data  = mainData;
    // Control is already zeroed whenever main drains; gating here also keeps
    // downstream safe against any stale control bits.
    assign out_ctrl  = mainValid ? mainCtrl : '0;

    // Next-state / next-datapath logic.
    always_comb begin
        mainValidNxt = mainValid;
        mainDataNxt  = mainData;
        mainCtrlNxt  = mainCtrl;
        skidValidNxt = skidValid;
        skidDataNxt  = skidData;
        skidCtrlNxt  = skidCtrl;

        if (flush) begin
            // Bubble: both entries dropped. A coincident pop has already been
            // taken by downstream, so nothing is lost from its point of view.
            mainValidNxt = 1'b0;
            skidValidNxt = 1'b0;
            mainCtrlNxt  = '0;
            skidCtrlNxt  = '0;
            if (CLEAR_DATA) begin
                mainDataNxt = '0;
                skidDataNxt = '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        mainValidNxt = 1'b1;
                        mainDataNxt  = in_data;
                        mainCtrlNxt  = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        mainDataNxt = in_data;
                        mainCtrlNxt = in_ctrl;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry in the skid.
                        skidValidNxt = 1'b1;
                        skidDataNxt  = in_data;
                        skidCtrlNxt  = in_ctrl;
                    end else if (pop) begin
                        mainValidNxt = 1'b0;
                        mainCtrlNxt  = '0;
                        if (CLEAR_DATA) mainDataNxt = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move things.
                    if (pop) begin
                        mainDataNxt  = skidData;
                        mainCtrlNxt  = skidCtrl;
                        skidValidNxt = 1'b0;
                        skidCtrlNxt  = '0;
                        if (CLEAR_DATA) skidDataNxt = '0;
                    end
                end
                default: begin
                    // Unreachable 2'b01; fall back to a clean EMPTY.
                    mainValidNxt = 1'b0;
                    skidValidNxt = 1'b0;
                    mainCtrlNxt  = '0;
                    skidCtrlNxt  = '0;
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            mainValid <= 1'b0;
            mainData  <= '0;
            mainCtrl  <= '0;
            skidValid <= 1'b0;
            skidData  <= '0;
            skidCtrl  <= '0;
        end else begin
            mainValid <= mainValidNxt;
            mainData  <= mainDataNxt;
            mainCtrl  <= mainCtrlNxt;
            skidValid <= skidValidNxt;
            skidData  <= skidDataNxt;
            skidCtrl  <= skidCtrlNxt;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters: they stop at 16'hFFFF instead of wrapping.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (!mainValid && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

    logic        clk = 1'b1;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic [31:0] inData;
    logic [11:0] inCtrl;
    logic        outReady;

    logic        inReady,  inReadyNc;
    logic        outValid, outValidNc;
    logic [31:0] outData,  outDataNc;
    logic [11:0] outCtrl,  outCtrlNc;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stallCnt,   bubbleCnt;
    logic [15:0] stallCntNc, bubbleCntNc;
`endif

    int checks = 0;
    int errors = 0;

    // Falling edge at 5, 15, 25, ...
    always #5 clk = ~clk;

    pipe_stage_elastic #(.DW(32), .CW(12), .CLEAR_DATA(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .in_ctrl   (inCtrl),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_ctrl  (outCtrl)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stallCnt),
        .bubble_cnt(bubbleCnt)
`endif
    );

    // Same stimulus, data registers retained on drain/flush.
    pipe_stage_elastic #(.DW(32), .CW(12), .CLEAR_DATA(1'b0)) dutNc (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReadyNc),
        .in_data   (inData),
        .in_ctrl   (inCtrl),
        .out_valid (outValidNc),
        .out_ready (outReady),
        .out_data  (outDataNc),
        .out_ctrl  (outCtrlNc)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stallCntNc),
        .bubble_cnt(bubbleCntNc)
`endif
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic [11:0] ic;
        logic        ordy;
        logic        expRdy;   // in_ready before the edge
        logic        expOv;    // after the edge
        logic [31:0] expOd;
        logic [11:0] expOc;
    } vecT;

    vecT vecs[$];

    function automatic vecT mk(logic fl, logic iv, logic [31:0] id, logic [11:0] ic,
                               logic ordy, logic expRdy, logic expOv,
                               logic [31:0] expOd, logic [11:0] expOc);
        vecT v;
        v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
        v.expRdy = expRdy; v.expOv = expOv; v.expOd = expOd; v.expOc = expOc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        // ---- table ----
        // streaming 1..8, out_ready=1
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, 32'(k), 12'h0A5, 1, 1, 1, 32'(k), 12'h0A5));
        vecs.push_back(mk(0, 0, 32'h0, 12'h0, 1, 1, 0, 32'h0, 12'h0));
        // backpressure A/B/C
        vecs.push_back(mk(0, 1, 32'h11, 12'h111, 0, 1, 1, 32'h11, 12'h111));
        vecs.push_back(mk(0, 1, 32'h22, 12'h222, 0, 1, 1, 32'h11, 12'h111));
        vecs.push_back(mk(0, 1, 32'h33, 12'h333, 0, 0, 1, 32'h11, 12'h111));
        vecs.push_back(mk(0, 1, 32'h33, 12'h333, 1, 0, 1, 32'h22, 12'h222));
        vecs.push_back(mk(0, 1, 32'h33, 12'h333, 1, 1, 1, 32'h33, 12'h333));
        vecs.push_back(mk(0, 0, 32'h0, 12'h0, 1, 1, 0, 32'h0, 12'h0));
        // flush while FULL, with 44 presented
        vecs.push_back(mk(0, 1, 32'h11, 12'h111, 0, 1, 1, 32'h11, 12'h111));
        vecs.push_back(mk(0, 1, 32'h22, 12'h222, 0, 1, 1, 32'h11, 12'h111));
        vecs.push_back(mk(1, 1, 32'h44, 12'h444, 0, 0, 0, 32'h0, 12'h0));
        vecs.push_back(mk(0, 0, 32'h0, 12'h0, 0, 1, 0, 32'h0, 12'h0));
        // accept+pop in ONE, then hold, then drain
        vecs.push_back(mk(0, 1, 32'h55, 12'h555, 0, 1, 1, 32'h55, 12'h555));
        vecs.push_back(mk(0, 1, 32'h66, 12'h666, 1, 1, 1, 32'h66, 12'h666));
        vecs.push_back(mk(0, 0, 32'h0, 12'h0, 0, 1, 1, 32'h66, 12'h666));
        vecs.push_back(mk(0, 0, 32'h0, 12'h0, 1, 1, 0, 32'h0, 12'h0));

        // ---- reset with input presented ----
        reset = 1'b0; flush = 1'b0; inValid = 1'b1; inData = 32'hDEADBEEF;
        inCtrl = 12'hFFF; outReady = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(outValid), 32'h0);
        chk("rst_out_data",  outData,       32'h0);
        chk("rst_out_ctrl",  32'(outCtrl),  32'h0);
        chk("rst_in_ready",  32'(inReady),  32'h0);
        @(posedge clk);
        inValid = 1'b0; inData = '0; inCtrl = '0;
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 32'(inReady), 32'h1);

`ifdef PIPE_STAGE_PERF_EN
        repeat (10) @(negedge clk);
        #1;
        chk("bubble_cnt_10", 32'(bubbleCnt), 32'd10);
`endif

        // ---- table replay ----
        @(negedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            flush    = vecs[i].fl;
            inValid  = vecs[i].iv;
            inData   = vecs[i].id;
            inCtrl   = vecs[i].ic;
            outReady = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(inReady), 32'(vecs[i].expRdy));
            @(negedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), 32'(outValid), 32'(vecs[i].expOv));
            chk($sformatf("v%0d_out_data", i),  outData,       vecs[i].expOd);
            chk($sformatf("v%0d_out_ctrl", i),  32'(outCtrl),  32'(vecs[i].expOc));
        end

        // CLEAR_DATA=0 copy: drained main keeps 66, control cleared.
        chk("nc_out_valid", 32'(outValidNc), 32'h0);
        chk("nc_out_data",  outDataNc,       32'h66);
        chk("nc_out_ctrl",  32'(outCtrlNc),  32'h0);

        // ---- reset asserted mid-transfer ----
        flush = 1'b0; inValid = 1'b1; inData = 32'h77; inCtrl = 12'h777; outReady = 1'b0;
        @(negedge clk); #1;
        chk("mid_out_data", outData, 32'h77);
        inValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(outValid), 32'h0);
        chk("mid_rst_out_data",  outData,       32'h0);
        chk("mid_rst_in_ready",  32'(inReady),  32'h0);
        @(posedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rel_in_ready", 32'(inReady), 32'h1);
        @(negedge clk); #1;
        chk("mid_rel_out_valid", 32'(outValid), 32'h0);

`ifdef PIPE_STAGE_PERF_EN
        // ---- stall counter saturation ----
        inValid = 1'b1; inData = 32'h88; inCtrl = 12'h888; outReady = 1'b0;
        repeat (70000) @(negedge clk);
        #1;
        chk("stall_cnt_sat", 32'(stallCnt), 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
